// File: rtl/multiciclo_core_param.sv
// rtl/multiciclo_core_param.sv - multicycle RV32/RV64 integer core on a unified req/ready memory port
module multiciclo_core_param #(
    parameter int          XLEN     = 64,
    parameter int          NREGS    = 32,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_size,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);
    localparam int              RW      = $clog2(NREGS);
    localparam logic [XLEN-1:0] PC_INIT = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, oldpc_q, oldpc_d;
    logic [31:0]      ir_q, ir_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0]  aluout_q, aluout_d, mdr_q, mdr_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  regs_q [NREGS];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic            dec_legal, alu_f3_ok;
    logic [3:0]      dec_next;
    logic [XLEN-1:0] imm_dec;
    logic [XLEN-1:0] opnd_b, sum, diff, alu_res, target, ld_data;
    logic            lt, taken, target_bad, retire;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    function automatic logic reg_ok(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    assign opcode    = ir_q[6:0];
    assign rd        = ir_q[11:7];
    assign funct3    = ir_q[14:12];
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign funct7    = ir_q[31:25];
    assign alu_f3_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};

    // Legality is fully resolved here so execute states never need to re-check.
    always_comb begin
        dec_legal = 1'b0;
        dec_next  = S_HALT;
        imm_dec   = '0;
        case (opcode)
            OP_LOAD: begin
                dec_legal = (funct3 == 3'b010 || (funct3 == 3'b011 && XLEN == 64))
                            && reg_ok(rd) && reg_ok(rs1);
                dec_next  = S_MEMADR;
                imm_dec   = XLEN'($signed(ir_q[31:20]));
            end
            OP_STORE: begin
                dec_legal = (funct3 == 3'b010 || (funct3 == 3'b011 && XLEN == 64))
                            && reg_ok(rs1) && reg_ok(rs2);
                dec_next  = S_MEMADR;
                imm_dec   = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
            end
            OP_REG: begin
                dec_legal = ((funct7 == 7'b0000000 && alu_f3_ok)
                             || (funct7 == 7'b0100000 && funct3 == 3'b000))
                            && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
                dec_next  = S_EXEC_R;
            end
            OP_IMM: begin
                dec_legal = alu_f3_ok && reg_ok(rd) && reg_ok(rs1);
                dec_next  = S_EXEC_I;
                imm_dec   = XLEN'($signed(ir_q[31:20]));
            end
            OP_BRANCH: begin
                dec_legal = (funct3 == 3'b000 || funct3 == 3'b001) && reg_ok(rs1) && reg_ok(rs2);
                dec_next  = S_BRANCH;
                imm_dec   = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
            end
            OP_JAL: begin
                dec_legal = reg_ok(rd);
                dec_next  = S_JAL;
                imm_dec   = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign opnd_b     = (state_q == S_EXEC_R) ? b_q : imm_q;
    assign sum        = a_q + opnd_b;
    assign diff       = a_q - opnd_b;
    assign lt         = $signed(a_q) < $signed(opnd_b);
    assign target     = oldpc_q + imm_q;
    assign target_bad = target[1:0] != 2'b00;
    assign taken      = funct3[0] ? (a_q != b_q) : (a_q == b_q);
    assign ld_data    = funct3[0] ? mem_rdata : XLEN'($signed(mem_rdata[31:0]));

    always_comb begin
        alu_res = sum;
        case (funct3)
            3'b000:  alu_res = (state_q == S_EXEC_R && funct7[5]) ? diff : sum;
            3'b010:  alu_res = XLEN'(lt);
            3'b110:  alu_res = a_q | opnd_b;
            3'b111:  alu_res = a_q & opnd_b;
            default: alu_res = sum;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rd[RW-1:0];
        rf_wdata = aluout_q;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d    = mem_rdata[31:0];
                oldpc_d = pc_q;
                pc_d    = pc_q + FOUR;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = regs_q[rs1[RW-1:0]];
                b_d     = regs_q[rs2[RW-1:0]];
                imm_d   = imm_dec;
                state_d = dec_legal ? dec_next : S_HALT;
            end
            S_MEMADR: begin
                aluout_d = sum;
                state_d  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: if (mem_ready) begin
                mdr_d   = ld_data;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: if (mem_ready) begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                aluout_d = alu_res;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            // A misaligned taken target halts with PC left at OLDPC+4.
            S_BRANCH: begin
                if (taken && target_bad) begin
                    state_d = S_HALT;
                end else begin
                    if (taken) pc_d = target;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_JAL: begin
                if (target_bad) begin
                    state_d = S_HALT;
                end else begin
                    pc_d     = target;
                    rf_we    = 1'b1;
                    rf_wdata = oldpc_q + FOUR;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_INIT;
            oldpc_q   <= PC_INIT;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            oldpc_q   <= oldpc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    // x0 is never written, so reading it always returns zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != '0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Request is gated by reset so it drops immediately when reset asserts.
    assign mem_req   = reset && (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE);
    assign mem_we    = reset && (state_q == S_MEMWRITE);
    assign mem_size  = (state_q != S_FETCH && funct3[0]) ? 2'b11 : 2'b10;
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : aluout_q;
    assign mem_wdata = b_q;
    assign pc_out    = pc_q;
    assign halted    = state_q == S_HALT;
    assign instret   = instret_q;
endmodule

// File: tb/tb_multiciclo_core_param.sv
// tb/tb_multiciclo_core_param.sv - directed-program bench for multiciclo_core_param
module tb_multiciclo_core_param;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [1:0]  instret;

    logic [31:0] imem [16];
    logic [7:0]  dmem [64];
    int          stall_req = 0;
    int          stall_done;
    logic        block64 = 1'b0;
    logic        ovr_en = 1'b0;
    logic [63:0] ovr_val = '0;
    logic [63:0] last_wa, last_wd, last_ra;
    logic [1:0]  last_ws;
    int          wr_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc;
    logic        found;

    multiciclo_core_param #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    assign mem_ready = !(mem_req && ((stall_done < stall_req) || (block64 && mem_addr == 64'd64)));

    always @* begin
        mem_rdata = '0;
        if (ovr_en && mem_addr == 64'd64) mem_rdata = ovr_val;
        else if (mem_addr < 64'd64) mem_rdata = {32'b0, imem[mem_addr[5:2]]};
        else for (int i = 0; i < 8; i++)
            if (mem_size == 2'b11 || i < 4) mem_rdata[i*8 +: 8] = dmem[(int'(mem_addr[5:0]) + i) % 64];
    end

    always @(posedge clk) begin
        if (!reset) stall_done <= 0;
        else if (mem_req && stall_done < stall_req) stall_done <= stall_done + 1;
        if (reset && mem_req && mem_ready && mem_we) begin
            for (int i = 0; i < 8; i++)
                if (mem_size == 2'b11 || i < 4) dmem[(int'(mem_addr[5:0]) + i) % 64] <= mem_wdata[i*8 +: 8];
            last_wa <= mem_addr;
            last_ws <= mem_size;
            last_wd <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
        if (reset && mem_req && mem_ready && !mem_we) last_ra <= mem_addr;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;
    endtask

    task automatic start_prog();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (halted !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        // Reset hold, then addi x1,x0,5 with three fetch wait states
        clear_imem();
        imem[0] = enc_i(5, 0, 3'b000, 1, 7'h13);
        imem[1] = 32'h0000_0073;
        stall_req = 3;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_pc", pc_out, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_instret", 64'(instret), 64'd0);
        reset = 1'b1;
        #1;
        chk("fetch0_size", 64'(mem_size), 64'd2);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) begin
                chk("fetch0_req", 64'(mem_req), 64'd1);
                chk("fetch0_addr", mem_addr, 64'd0);
            end
            if (c == 7) chk("ws_instret_before", 64'(instret), 64'd0);
            if (c == 8) begin
                chk("ws_instret_after", 64'(instret), 64'd1);
                chk("ws_next_fetch", mem_addr, 64'd4);
                chk("ws_x1", dut.regs_q[1], 64'd5);
            end
            @(negedge clk);
        end
        run_to_halt(cyc);
        chk("ecall_halted", 64'(halted), 64'd1);
        chk("ecall_req", 64'(mem_req), 64'd0);
        chk("ecall_instret", 64'(instret), 64'd1);
        chk("ecall_pc", pc_out, 64'd8);
        stall_req = 0;

        // ALU and taken beq
        clear_imem();
        imem[0] = enc_i(-3, 0, 3'b000, 1, 7'h13);
        imem[1] = enc_i(7, 0, 3'b000, 2, 7'h13);
        imem[2] = enc_r(7'h00, 2, 1, 3'b010, 3);
        imem[3] = enc_r(7'h20, 1, 2, 3'b000, 4);
        imem[4] = enc_b(8, 3, 3, 3'b000);
        imem[5] = enc_i(1, 0, 3'b000, 9, 7'h13);
        imem[6] = 32'h0000_0073;
        start_prog();
        run_to_halt(cyc);
        chk("alu_cycles", 64'(cyc), 64'd21);
        chk("alu_x1", dut.regs_q[1], 64'hFFFF_FFFF_FFFF_FFFD);
        chk("alu_x3_slt", dut.regs_q[3], 64'd1);
        chk("alu_x4_sub", dut.regs_q[4], 64'd10);
        chk("beq_skipped_x9", dut.regs_q[9], 64'd0);
        chk("beq_target_fetch", last_ra, 64'd24);
        chk("beq_pc", pc_out, 64'd28);
        chk("alu_instret", 64'(instret), 64'd1);

        // sd / lw / ld round trip
        clear_imem();
        imem[0] = enc_i(-1, 0, 3'b000, 5, 7'h13);
        imem[1] = enc_s(64, 5, 0, 3'b011);
        imem[2] = enc_i(64, 0, 3'b010, 6, 7'h03);
        imem[3] = enc_i(64, 0, 3'b011, 7, 7'h03);
        imem[4] = 32'h0000_0073;
        start_prog();
        run_to_halt(cyc);
        chk("ls_cycles", 64'(cyc), 64'd20);
        chk("sd_count", 64'(wr_cnt), 64'd1);
        chk("sd_addr", last_wa, 64'd64);
        chk("sd_size", 64'(last_ws), 64'd3);
        chk("sd_data", last_wd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lw_x6", dut.regs_q[6], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ld_x7", dut.regs_q[7], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ls_instret_wrap0", 64'(instret), 64'd0);

        // lw sign-extends bit 31, ld does not
        clear_imem();
        imem[0] = enc_i(64, 0, 3'b010, 6, 7'h03);
        imem[1] = enc_i(64, 0, 3'b011, 7, 7'h03);
        imem[2] = 32'h0000_0073;
        ovr_en  = 1'b1;
        ovr_val = 64'h0000_0000_8000_0000;
        start_prog();
        run_to_halt(cyc);
        chk("lw_sext_cycles", 64'(cyc), 64'd12);
        chk("lw_sext_x6", dut.regs_q[6], 64'hFFFF_FFFF_8000_0000);
        chk("ld_zext_x7", dut.regs_q[7], 64'h0000_0000_8000_0000);
        ovr_en = 1'b0;

        // x0 write discard, R logic ops, jal at 0x10
        clear_imem();
        imem[0] = enc_i(9, 0, 3'b000, 0, 7'h13);
        imem[1] = enc_i(2, 0, 3'b000, 8, 7'h13);
        imem[2] = enc_r(7'h00, 8, 8, 3'b111, 10);
        imem[3] = enc_r(7'h00, 0, 8, 3'b110, 11);
        imem[4] = enc_j(12, 1);
        imem[5] = enc_i(1, 0, 3'b000, 9, 7'h13);
        imem[6] = enc_i(1, 0, 3'b000, 9, 7'h13);
        imem[7] = 32'h0000_0073;
        start_prog();
        run_to_halt(cyc);
        chk("jal_cycles", 64'(cyc), 64'd21);
        chk("x0_zero", dut.regs_q[0], 64'd0);
        chk("and_x10", dut.regs_q[10], 64'd2);
        chk("or_x11", dut.regs_q[11], 64'd2);
        chk("jal_link_x1", dut.regs_q[1], 64'h14);
        chk("jal_skip_x9", dut.regs_q[9], 64'd0);
        chk("jal_target_fetch", last_ra, 64'h1C);
        chk("jal_instret_wrap", 64'(instret), 64'd1);

        // Misaligned jal target halts without retiring
        clear_imem();
        imem[0] = enc_j(2, 1);
        start_prog();
        run_to_halt(cyc);
        chk("misjal_cycles", 64'(cyc), 64'd3);
        chk("misjal_halted", 64'(halted), 64'd1);
        chk("misjal_pc", pc_out, 64'd4);
        chk("misjal_x1", dut.regs_q[1], 64'd0);
        chk("misjal_instret", 64'(instret), 64'd0);

        // Unlisted funct7 is illegal
        clear_imem();
        imem[0] = enc_r(7'h01, 2, 1, 3'b000, 3);
        start_prog();
        run_to_halt(cyc);
        chk("illegal_cycles", 64'(cyc), 64'd2);
        chk("illegal_pc", pc_out, 64'd4);
        chk("illegal_instret", 64'(instret), 64'd0);

        // Reset while a load is stalled
        clear_imem();
        imem[0] = enc_i(3, 0, 3'b000, 6, 7'h13);
        imem[1] = enc_i(64, 0, 3'b010, 6, 7'h03);
        block64 = 1'b1;
        start_prog();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 64'd64) found = 1'b1;
        end
        chk("memread_seen", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        chk("memread_still_req", 64'(mem_req), 64'd1);
        chk("pre_rst_x6", dut.regs_q[6], 64'd3);
        reset = 1'b0;
        #1;
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_pc", pc_out, 64'd0);
        chk("midrst_x6", dut.regs_q[6], 64'd0);
        chk("midrst_instret", 64'(instret), 64'd0);
        block64 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
